// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-port round-robin front end that shares one external ALU.
//               Each operation takes three cycles (IDLE, ISSUE, RESP).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_branch_op,
    input  logic [5:0]            req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_opA,
    input  logic [DATA_WIDTH-1:0] req0_opB,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_branch_op,
    input  logic [5:0]            req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_opA,
    input  logic [DATA_WIDTH-1:0] req1_opB,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_branch,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_branch,
    output logic                  alu_branch_op,
    output logic [5:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_operand_A,
    output logic [DATA_WIDTH-1:0] alu_operand_B,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_branch,
    output logic                  busy,
    output logic [15:0]           done_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_grant;
    logic                  r_prio;
    logic                  r_branch_op;
    logic [5:0]            r_ctrl;
    logic [DATA_WIDTH-1:0] r_op_a;
    logic [DATA_WIDTH-1:0] r_op_b;
    logic [DATA_WIDTH-1:0] r_rsp0_result;
    logic [DATA_WIDTH-1:0] r_rsp1_result;
    logic                  r_rsp0_branch;
    logic                  r_rsp1_branch;
    logic [15:0]           r_done_count;

    logic                  w_grant;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_rsp_ready;

    // Contention is settled by the pointer; a lone requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = r_prio;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept    = !reset && (r_state == IDLE) && (req0_valid || req1_valid);
    assign w_issue     = (r_state == ISSUE);
    assign w_rsp_ready = r_grant ? rsp1_ready : rsp0_ready;

    assign req0_ready    = w_accept && !w_grant;
    assign req1_ready    = w_accept && w_grant;

    assign alu_branch_op = w_issue ? r_branch_op : 1'b0;
    assign alu_ctrl      = w_issue ? r_ctrl : 6'd0;
    assign alu_operand_A = w_issue ? r_op_a : '0;
    assign alu_operand_B = w_issue ? r_op_b : '0;

    assign rsp0_valid    = (r_state == RESP) && !r_grant;
    assign rsp1_valid    = (r_state == RESP) && r_grant;
    assign rsp0_result   = r_rsp0_result;
    assign rsp1_result   = r_rsp1_result;
    assign rsp0_branch   = r_rsp0_branch;
    assign rsp1_branch   = r_rsp1_branch;
    assign busy          = (r_state != IDLE);
    assign done_count    = r_done_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= 1'b0;
            r_prio        <= 1'b0;
            r_branch_op   <= 1'b0;
            r_ctrl        <= 6'd0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
            r_rsp0_branch <= 1'b0;
            r_rsp1_branch <= 1'b0;
            r_done_count  <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grant     <= w_grant;
                        r_branch_op <= w_grant ? req1_branch_op : req0_branch_op;
                        r_ctrl      <= w_grant ? req1_ctrl      : req0_ctrl;
                        r_op_a      <= w_grant ? req1_opA       : req0_opA;
                        r_op_b      <= w_grant ? req1_opB       : req0_opB;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_grant) begin
                        r_rsp1_result <= alu_result;
                        r_rsp1_branch <= alu_branch & r_branch_op;
                    end else begin
                        r_rsp0_result <= alu_result;
                        r_rsp0_branch <= alu_branch & r_branch_op;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (w_rsp_ready) begin
                        r_prio       <= ~r_grant;
                        r_done_count <= r_done_count + 16'd1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Randomized self-checking bench for alu_arbiter with an ALU stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_branch_op;
    logic [5:0]  req0_ctrl;
    logic [31:0] req0_opA, req0_opB;
    logic        req1_valid, req1_ready, req1_branch_op;
    logic [5:0]  req1_ctrl;
    logic [31:0] req1_opA, req1_opB;
    logic        rsp0_valid, rsp0_ready, rsp0_branch;
    logic [31:0] rsp0_result;
    logic        rsp1_valid, rsp1_ready, rsp1_branch;
    logic [31:0] rsp1_result;
    logic        alu_branch_op;
    logic [5:0]  alu_ctrl;
    logic [31:0] alu_operand_A, alu_operand_B;
    logic [31:0] alu_result;
    logic        alu_branch;
    logic        busy;
    logic [15:0] done_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_prio = 1'b0;
    int exp_done = 0;

    always #5 clock = ~clock;

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_branch_op(req0_branch_op),
        .req0_ctrl(req0_ctrl), .req0_opA(req0_opA), .req0_opB(req0_opB),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_branch_op(req1_branch_op),
        .req1_ctrl(req1_ctrl), .req1_opA(req1_opA), .req1_opB(req1_opB),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_branch(rsp0_branch),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_branch(rsp1_branch),
        .alu_branch_op(alu_branch_op), .alu_ctrl(alu_ctrl),
        .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
        .alu_result(alu_result), .alu_branch(alu_branch),
        .busy(busy), .done_count(done_count)
    );

    // ALU semantics: {branch_condition, result}
    function automatic logic [32:0] alu_fn(input logic [5:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            6'd0:    return {1'b0, a + b};
            6'd1:    return {1'b0, a - b};
            6'd2:    return {1'b0, a ^ b};
            6'd3:    return {1'b0, a & b};
            6'd4:    return {1'b0, a | b};
            6'd5:    return {(a == b), 32'h0};
            6'd6:    return {(a < b), 32'h0};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb begin
        {alu_branch, alu_result} = alu_fn(alu_ctrl, alu_operand_A, alu_operand_B);
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_value({tag, "_busy"}, 32'(busy), 32'd0);
        check_value({tag, "_rspv"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check_value({tag, "_res0"}, rsp0_result, 32'd0);
        check_value({tag, "_res1"}, rsp1_result, 32'd0);
        check_value({tag, "_br"}, 32'({rsp1_branch, rsp0_branch}), 32'd0);
        check_value({tag, "_alu"}, alu_operand_A | alu_operand_B | 32'(alu_ctrl)
                                   | 32'(alu_branch_op), 32'd0);
        check_value({tag, "_done"}, 32'(done_count), 32'd0);
    endtask

    // One full transaction; post_v gives the request valids held after acceptance.
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [5:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                          input bit bo0,
                          input logic [5:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                          input bit bo1,
                          input int stall, input logic [1:0] post_v,
                          output logic [31:0] res, output logic br);
        bit g, eg;
        logic [5:0] c;
        logic [31:0] a, b;
        bit bo;
        logic [32:0] r;
        logic [31:0] exp_res;
        bit exp_br;
        @(negedge clock);
        req0_valid = v0; req0_ctrl = c0; req0_opA = a0; req0_opB = b0; req0_branch_op = bo0;
        req1_valid = v1; req1_ctrl = c1; req1_opA = a1; req1_opB = b1; req1_branch_op = bo1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        g  = (v0 && v1) ? exp_prio : v1;
        c  = g ? c1 : c0;
        a  = g ? a1 : a0;
        b  = g ? b1 : b0;
        bo = g ? bo1 : bo0;
        r  = alu_fn(c, a, b);
        exp_res = r[31:0];
        exp_br  = r[32] & bo;
        #1;
        check_value("grant_ready0", 32'(req0_ready), 32'(!g));
        check_value("grant_ready1", 32'(req1_ready), 32'(g));
        check_value("idle_busy", 32'(busy), 32'd0);
        @(negedge clock);
        req0_valid = post_v[0]; req1_valid = post_v[1];
        req0_opA = $urandom; req0_opB = $urandom; req0_ctrl = 6'($urandom_range(0, 7));
        req1_opA = $urandom; req1_opB = $urandom; req1_ctrl = 6'($urandom_range(0, 7));
        req0_branch_op = 1'($urandom_range(0, 1)); req1_branch_op = 1'($urandom_range(0, 1));
        #1;
        check_value("issue_busy", 32'(busy), 32'd1);
        check_value("issue_ready", 32'({req1_ready, req0_ready}), 32'd0);
        check_value("issue_ctrl", 32'(alu_ctrl), 32'(c));
        check_value("issue_opA", alu_operand_A, a);
        check_value("issue_opB", alu_operand_B, b);
        check_value("issue_bop", 32'(alu_branch_op), 32'(bo));
        check_value("issue_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        @(negedge clock);
        #1;
        check_value("resp_valid", 32'({rsp1_valid, rsp0_valid}), g ? 32'd2 : 32'd1);
        check_value("resp_result", g ? rsp1_result : rsp0_result, exp_res);
        check_value("resp_branch", 32'(g ? rsp1_branch : rsp0_branch), 32'(exp_br));
        check_value("resp_alu_idle", alu_operand_A | 32'(alu_ctrl), 32'd0);
        res = g ? rsp1_result : rsp0_result;
        br  = g ? rsp1_branch : rsp0_branch;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            if (g) rsp0_ready = 1'($urandom_range(0, 1));
            else   rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            check_value("stall_valid", 32'({rsp1_valid, rsp0_valid}), g ? 32'd2 : 32'd1);
            check_value("stall_result", g ? rsp1_result : rsp0_result, exp_res);
            check_value("stall_branch", 32'(g ? rsp1_branch : rsp0_branch), 32'(exp_br));
            check_value("stall_ready", 32'({req1_ready, req0_ready}), 32'd0);
        end
        if (g) rsp1_ready = 1'b1;
        else   rsp0_ready = 1'b1;
        #1;
        check_value("hs_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clock);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        exp_prio = !g;
        exp_done = (exp_done + 1) % 65536;
        eg = (post_v == 2'b11) ? exp_prio : post_v[1];
        #1;
        check_value("hs_busy", 32'(busy), 32'd0);
        check_value("hs_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check_value("hs_done", 32'(done_count), 32'(exp_done));
        check_value("reidle_ready0", 32'(req0_ready), 32'((post_v != 2'b00) && !eg));
        check_value("reidle_ready1", 32'(req1_ready), 32'((post_v != 2'b00) && eg));
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Abort an operation with reset in ISSUE (when_resp=0) or RESP (when_resp=1).
    task automatic reset_during(input bit when_resp);
        @(negedge clock);
        req0_valid = 1'b1; req0_ctrl = 6'd0; req0_opA = 32'd100; req0_opB = 32'd23;
        req1_valid = 1'b1; req1_ctrl = 6'd2; req1_opA = 32'hF0F0; req1_opB = 32'h0FF0;
        @(negedge clock);
        if (when_resp) @(negedge clock);
        reset = 1'b1;
        #1;
        check_value("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clock);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        exp_prio = 1'b0; exp_done = 0;
        #1;
        check_idle_zero(when_resp ? "rst_resp" : "rst_issue");
        repeat (3) @(negedge clock);
        #1;
        check_value("rst_no_rsp", 32'({busy, rsp1_valid, rsp0_valid}), 32'd0);
    endtask

    logic [31:0] res;
    logic        br;

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 6'd0; req0_opA = 32'd0; req0_opB = 32'd0; req0_branch_op = 1'b0;
        req1_valid = 1'b1; req1_ctrl = 6'd0; req1_opA = 32'd0; req1_opB = 32'd0; req1_branch_op = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_value("por_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clock);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check_idle_zero("por");

        // Single ADD on port 0
        do_txn(1'b1, 1'b0, 6'd0, 32'd4, 32'd5, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 0, 2'b00, res, br);
        check_value("add_result", res, 32'd9);
        check_value("add_branch", 32'(br), 32'd0);
        check_value("add_done", 32'(done_count), 32'd1);

        reset_during(1'b0);

        // Contention straight after reset: port 0 first, then port 1, then port 0 again
        do_txn(1'b1, 1'b1, 6'd1, 32'd12, 32'd5, 1'b0, 6'd2, 32'd12, 32'd5, 1'b0, 0, 2'b00, res, br);
        check_value("sub_result", res, 32'd7);
        do_txn(1'b0, 1'b1, 6'd1, 32'd12, 32'd5, 1'b0, 6'd2, 32'd12, 32'd5, 1'b0, 0, 2'b00, res, br);
        check_value("xor_result", res, 32'd9);
        do_txn(1'b1, 1'b1, 6'd3, 32'hFF, 32'h0F, 1'b0, 6'd4, 32'h1, 32'h2, 1'b0, 1, 2'b00, res, br);
        check_value("ptr_back_port0", res, 32'h0F);

        // BEQ on port 1 with and without the branch qualifier
        do_txn(1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 1'b0, 6'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
               0, 2'b00, res, br);
        check_value("beq_taken", 32'(br), 32'd1);
        do_txn(1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 1'b0, 6'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
               0, 2'b00, res, br);
        check_value("beq_masked", 32'(br), 32'd0);

        // Back-pressure on port 0 while port 1 waits
        do_txn(1'b1, 1'b1, 6'd0, 32'd1, 32'd2, 1'b0, 6'd0, 32'd3, 32'd4, 1'b0, 3, 2'b10, res, br);
        check_value("bp_result", res, 32'd3);

        reset_during(1'b1);

        for (int n = 0; n < 300; n++) begin
            logic [1:0]  v;
            logic [31:0] ra0, ra1, rb0, rb1;
            v   = 2'($urandom_range(1, 3));
            ra0 = $urandom;
            ra1 = $urandom;
            rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
            do_txn(v[0], v[1],
                   6'($urandom_range(0, 7)), ra0, rb0, 1'($urandom_range(0, 1)),
                   6'($urandom_range(0, 7)), ra1, rb1, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), res, br);
        end

        // done_count wrap
        @(negedge clock);
        force dut.r_done_count = 16'hFFFF;
        #1;
        release dut.r_done_count;
        exp_done = 16'hFFFF;
        check_value("wrap_preload", 32'(done_count), 32'hFFFF);
        do_txn(1'b1, 1'b0, 6'd0, 32'd1, 32'd1, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 0, 2'b00, res, br);
        check_value("wrap_zero", 32'(done_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
